eth_mac_10g_tx_pause_ctrl: RTL

- 802.3x PAUSE controller in the tx_clk domain, between the TX async FIFO output and the 10G MAC TX AXI-stream input.
- Injects locally requested PAUSE frames at frame boundaries.
- Honours PAUSE quanta received from the link partner by stalling user data after the frame in progress completes.
- Never interrupts a frame mid-stream.

---
 rtl/eth_mac_10g_tx_pause_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/eth_mac_10g_tx_pause_ctrl.sv
// 802.3x PAUSE controller between the TX FIFO and the 10G MAC TX stream.
// Injects local PAUSE frames and honours received quanta, only at frame boundaries.
module eth_mac_10g_tx_pause_ctrl #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH    = 1,
  parameter int unsigned QUANTA_CYCLES = 8,
  parameter int unsigned TIMER_WIDTH   = 19
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic                  tx_pause_send,
  input  logic [15:0]           tx_pause_quanta,
  input  logic                  rx_pause_valid,
  input  logic [15:0]           rx_pause_quanta,
  input  logic [47:0]           cfg_src_mac,
  input  logic                  cfg_rx_pause_enable,

  output logic                  stat_tx_pause_sent,
  output logic                  stat_rx_paused
);

  typedef enum logic [1:0] {StIdle, StData, StPauseFrm} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             word_q, word_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   pending_q, pending_d;
  logic [15:0]            pend_quanta_q, pend_quanta_d;
  logic [15:0]            frm_quanta_q, frm_quanta_d;
  logic [47:0]            frm_sa_q, frm_sa_d;
  logic                   frm_start;
  logic [63:0]            pause_word;

  assign frm_start = (state_q == StIdle) && pending_q;

  // A request in the start cycle wins over the clear, so it re-arms a second frame.
  always_comb begin
    pend_quanta_d = pend_quanta_q;
    pending_d     = pending_q;
    frm_quanta_d  = frm_quanta_q;
    frm_sa_d      = frm_sa_q;
    if (frm_start) begin
      pending_d    = 1'b0;
      frm_quanta_d = pend_quanta_q;
      frm_sa_d     = cfg_src_mac;
    end
    if (tx_pause_send) begin
      pending_d     = 1'b1;
      pend_quanta_d = tx_pause_quanta;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (rx_pause_valid && cfg_rx_pause_enable) begin
      timer_d = TIMER_WIDTH'(rx_pause_quanta) * TIMER_WIDTH'(QUANTA_CYCLES);
    end else if (timer_q != '0) begin
      timer_d = timer_q - TIMER_WIDTH'(1);
    end
  end

  // Byte 0 of each word sits on tdata[7:0].
  always_comb begin
    pause_word = 64'h0;
    unique case (word_q)
      3'd0: pause_word = {frm_sa_q[39:32], frm_sa_q[47:40], 48'h0100_00C2_8001};
      3'd1: pause_word = {32'h0100_0888, frm_sa_q[7:0], frm_sa_q[15:8],
                          frm_sa_q[23:16], frm_sa_q[31:24]};
      3'd2: pause_word = {48'h0, frm_quanta_q[7:0], frm_quanta_q[15:8]};
      default: pause_word = 64'h0;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    word_d             = word_q;
    s_axis_tready      = 1'b0;
    m_axis_tdata       = '0;
    m_axis_tkeep       = '0;
    m_axis_tvalid      = 1'b0;
    m_axis_tlast       = 1'b0;
    m_axis_tuser       = '0;
    stat_tx_pause_sent = 1'b0;
    stat_rx_paused     = (timer_q != '0);

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d = StPauseFrm;
          word_d  = 3'd0;
        end else if (timer_q == '0) begin
          s_axis_tready = m_axis_tready;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tkeep  = s_axis_tkeep;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tlast  = s_axis_tlast;
          m_axis_tuser  = s_axis_tuser;
          if (s_axis_tvalid && m_axis_tready && !s_axis_tlast) begin
            state_d = StData;
          end
        end
      end
      StData: begin
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d = StIdle;
        end
      end
      StPauseFrm: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = DATA_WIDTH'(pause_word);
        m_axis_tkeep  = (word_q == 3'd7) ? KEEP_WIDTH'(8'h0F) : KEEP_WIDTH'(8'hFF);
        m_axis_tlast  = (word_q == 3'd7);
        if (m_axis_tready) begin
          if (word_q == 3'd7) begin
            stat_tx_pause_sent = 1'b1;
            state_d            = StIdle;
          end else begin
            word_d = word_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are forced low for the whole reset, not just from the next edge.
    if (tx_rst) begin
      s_axis_tready      = 1'b0;
      m_axis_tdata       = '0;
      m_axis_tkeep       = '0;
      m_axis_tvalid      = 1'b0;
      m_axis_tlast       = 1'b0;
      m_axis_tuser       = '0;
      stat_tx_pause_sent = 1'b0;
      stat_rx_paused     = 1'b0;
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q       <= StIdle;
      word_q        <= 3'd0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      pend_quanta_q <= 16'h0;
      frm_quanta_q  <= 16'h0;
      frm_sa_q      <= 48'h0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      pend_quanta_q <= pend_quanta_d;
      frm_quanta_q  <= frm_quanta_d;
      frm_sa_q      <= frm_sa_d;
    end
  end

endmodule
